// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: hazard-control inputs, branch targets, imem port and the decode-facing fetch latch.
// slave = fetch stage, master = hazard control / decode / ROM side.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 18
);
  logic                   pc_reset;
  logic                   pc_load;
  logic                   pc_inc;
  logic [2:0]             pc_mux_sel;
  logic                   imem_addr_mux;
  logic                   fetch_latch_stall;
  logic                   fetch_flush;
  logic [PC_WIDTH-1:0]    imm_target;
  logic [PC_WIDTH-1:0]    stack_target;
  logic [PC_WIDTH-1:0]    miss_target;
  logic [PC_WIDTH-1:0]    pred_target;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [INSTR_WIDTH-1:0] fetch_instr;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic                   fetch_valid;
  logic [PC_WIDTH-1:0]    pc_out;

  modport master (
    output pc_reset, pc_load, pc_inc, pc_mux_sel, imem_addr_mux,
           fetch_latch_stall, fetch_flush,
           imm_target, stack_target, miss_target, pred_target, imem_data,
    input  imem_addr, fetch_instr, fetch_pc, fetch_valid, pc_out
  );

  modport slave (
    input  pc_reset, pc_load, pc_inc, pc_mux_sel, imem_addr_mux,
           fetch_latch_stall, fetch_flush,
           imm_target, stack_target, miss_target, pred_target, imem_data,
    output imem_addr, fetch_instr, fetch_pc, fetch_valid, pc_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address mux (replay of last address) and fetch latch to decode.
// Latency: address issued in cycle n lands in the latch on the edge ending n+1; stall holds the latch.
module fetch_stage #(
  parameter int                  PC_WIDTH     = 10,
  parameter int                  INSTR_WIDTH  = 18,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 'h000,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR   = 'h3FF
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   valid;
  } fetch_t;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] addr_q;
  logic [PC_WIDTH-1:0] load_target;
  logic                rom_valid;
  fetch_t              latch_q;
  fetch_t              latch_next;

  assign bus.imem_addr = bus.imem_addr_mux ? addr_q : pc;

  // Illegal selects resolve to the current PC so a bad load leaves the PC untouched.
  always_comb begin
    load_target = pc;
    case (bus.pc_mux_sel)
      3'd0:    load_target = bus.imm_target;
      3'd1:    load_target = bus.stack_target;
      3'd2:    load_target = INT_VECTOR;
      3'd3:    load_target = bus.miss_target;
      3'd4:    load_target = bus.pred_target;
      default: load_target = pc;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (bus.pc_reset)
      pc_next = RESET_VECTOR;
    else if (bus.pc_load)
      pc_next = load_target;
    else if (bus.pc_inc)
      pc_next = pc + PC_WIDTH'(1);
  end

  always_comb begin
    latch_next = latch_q;
    if (bus.pc_reset || bus.fetch_flush)
      latch_next.valid = 1'b0;
    else if (!bus.fetch_latch_stall) begin
      latch_next.instr = bus.imem_data;
      latch_next.pc    = addr_q;
      latch_next.valid = rom_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      addr_q    <= RESET_VECTOR;
      rom_valid <= 1'b0;
      latch_q   <= '0;
    end else begin
      pc        <= pc_next;
      addr_q    <= bus.imem_addr;
      rom_valid <= !bus.pc_reset;
      latch_q   <= latch_next;
    end
  end

  assign bus.pc_out      = pc;
  assign bus.fetch_instr = latch_q.instr;
  assign bus.fetch_pc    = latch_q.pc;
  assign bus.fetch_valid = latch_q.valid;

  ap_legal_sel: assert property (@(posedge clk) disable iff (reset)
    (bus.pc_load && !bus.pc_reset) |-> (bus.pc_mux_sel <= 3'd4))
    else $warning("fetch_stage: illegal pc_mux_sel %0d on pc_load, pc held", bus.pc_mux_sel);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle synchronous ROM where ROM[a] = a + 0x100.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_stage_if #(.PC_WIDTH(10), .INSTR_WIDTH(18)) bus ();

  fetch_stage #(.PC_WIDTH(10), .INSTR_WIDTH(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_data <= {8'h00, bus.imem_addr} + 18'h100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_latch(input string tag, input logic [9:0] pc_e, input logic valid_e);
    check({tag, ".valid"}, 32'(bus.fetch_valid), 32'(valid_e));
    check({tag, ".pc"},    32'(bus.fetch_pc),    32'(pc_e));
    check({tag, ".instr"}, 32'(bus.fetch_instr), 32'({8'h00, pc_e} + 18'h100));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset                 = 1'b1;
    bus.pc_reset          = 1'b0;
    bus.pc_load           = 1'b0;
    bus.pc_inc            = 1'b0;
    bus.pc_mux_sel        = 3'd0;
    bus.imem_addr_mux     = 1'b0;
    bus.fetch_latch_stall = 1'b0;
    bus.fetch_flush       = 1'b0;
    bus.imm_target        = 10'h000;
    bus.stack_target      = 10'h055;
    bus.miss_target       = 10'h040;
    bus.pred_target       = 10'h010;
    #3;
    check("rst.pc",    32'(bus.pc_out),      32'h0);
    check("rst.valid", 32'(bus.fetch_valid), 32'h0);
    check("rst.fpc",   32'(bus.fetch_pc),    32'h0);
    check("rst.instr", 32'(bus.fetch_instr), 32'h0);
    check("rst.addr",  32'(bus.imem_addr),   32'h0);

    // Sequential fetch from reset
    @(negedge clk);
    reset      = 1'b0;
    bus.pc_inc = 1'b1;
    step();
    check("seq1.pc",    32'(bus.pc_out),      32'h1);
    check("seq1.valid", 32'(bus.fetch_valid), 32'h0);
    step();
    check("seq2.pc", 32'(bus.pc_out), 32'h2);
    chk_latch("seq2", 10'h000, 1'b1);
    step();
    chk_latch("seq3", 10'h001, 1'b1);

    // Wrap 0x3FF -> 0x000
    bus.pc_load    = 1'b1;
    bus.pc_mux_sel = 3'd0;
    bus.imm_target = 10'h3FE;
    step();
    check("wrap.load", 32'(bus.pc_out), 32'h3FE);
    bus.pc_load = 1'b0;
    step();
    check("wrap.pc3ff", 32'(bus.pc_out), 32'h3FF);
    step();
    check("wrap.pc0", 32'(bus.pc_out), 32'h000);
    chk_latch("wrap.a", 10'h3FE, 1'b1);
    step();
    chk_latch("wrap.b", 10'h3FF, 1'b1);
    step();
    chk_latch("wrap.c", 10'h000, 1'b1);

    // Mispredict recovery: load with inc also high, load wins
    bus.pc_load    = 1'b1;
    bus.pc_mux_sel = 3'd3;
    step();
    check("miss.pc", 32'(bus.pc_out), 32'h040);
    bus.pc_load = 1'b0;
    step();
    step();
    chk_latch("miss", 10'h040, 1'b1);

    // Remaining legal sources
    bus.pc_load    = 1'b1;
    bus.pc_mux_sel = 3'd2;
    step();
    check("int.pc", 32'(bus.pc_out), 32'h3FF);
    bus.pc_mux_sel = 3'd1;
    step();
    check("stack.pc", 32'(bus.pc_out), 32'h055);
    bus.pc_mux_sel = 3'd4;
    step();
    check("pred.pc", 32'(bus.pc_out), 32'h010);
    bus.pc_load = 1'b0;
    step();
    step();
    step();
    check("pre.addr", 32'(bus.pc_out), 32'h013);
    chk_latch("pre", 10'h011, 1'b1);

    // Replay: stall + address mux for three cycles on 0x012
    bus.pc_inc            = 1'b0;
    bus.fetch_latch_stall = 1'b1;
    bus.imem_addr_mux     = 1'b1;
    #1;
    check("rep.addr0", 32'(bus.imem_addr), 32'h012);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rep.addr%0d", i + 1), 32'(bus.imem_addr), 32'h012);
      chk_latch($sformatf("rep.hold%0d", i + 1), 10'h011, 1'b1);
    end
    bus.fetch_latch_stall = 1'b0;
    bus.imem_addr_mux     = 1'b0;
    bus.pc_inc            = 1'b1;
    step();
    chk_latch("rep.rel1", 10'h012, 1'b1);
    step();
    chk_latch("rep.rel2", 10'h013, 1'b1);

    // Flush while stalled, then pc_reset mid-stall
    bus.pc_inc            = 1'b0;
    bus.fetch_latch_stall = 1'b1;
    bus.fetch_flush       = 1'b1;
    step();
    check("flush.valid", 32'(bus.fetch_valid), 32'h0);
    check("flush.fpc",   32'(bus.fetch_pc),    32'h013);
    bus.fetch_flush = 1'b0;
    bus.pc_reset    = 1'b1;
    step();
    check("pcrst.pc",    32'(bus.pc_out),      32'h000);
    check("pcrst.valid", 32'(bus.fetch_valid), 32'h0);
    bus.pc_reset          = 1'b0;
    bus.fetch_latch_stall = 1'b0;
    bus.pc_inc            = 1'b1;
    step();
    check("restart1.valid", 32'(bus.fetch_valid), 32'h0);
    step();
    chk_latch("restart2", 10'h000, 1'b1);
    check("restart2.pc", 32'(bus.pc_out), 32'h002);

    // Illegal select: PC holds
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b1;
    bus.pc_mux_sel = 3'd5;
    step();
    check("illegal.pc", 32'(bus.pc_out), 32'h002);
    bus.pc_load = 1'b0;

    // Async reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst.pc",    32'(bus.pc_out),      32'h0);
    check("arst.valid", 32'(bus.fetch_valid), 32'h0);
    check("arst.fpc",   32'(bus.fetch_pc),    32'h0);
    check("arst.instr", 32'(bus.fetch_instr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
